// File: rtl/jp_serial_scan.sv
// SNES-style serial gamepad poller: drives latch/clock, samples data, debounces
// the decoded buttons, modulates turbo A/B and flags an absent pad.
module jp_serial_scan #(
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 30000,
  parameter int DEBOUNCE    = 2,
  parameter int TURBO_DIV   = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_jp_data,
  output logic       o_jp_latch,
  output logic       o_jp_clk,
  output logic [9:0] o_jp_vec,
  output logic       o_pad_present,
  output logic       o_scan_done
);
  localparam int WAIT_W = $clog2(SCAN_PERIOD + 1);
  localparam int CNT_W  = $clog2(2 * CLK_DIV + 1);
  localparam int TD_W   = $clog2(TURBO_DIV + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  PH_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [TD_W-1:0]   TD_LAST    = TD_W'(TURBO_DIV - 1);
  localparam logic [3:0]        DB         = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        sync_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bit_q;
  logic [15:0]       raw_q;
  logic              latch_q, jclk_q, done_q, present_q;
  logic [9:0]        prev_q, prev_d, stable_q, stable_d, vec_q, dec;
  logic [3:0]        match_q, match_d;
  logic [TD_W-1:0]   tcnt_q, tcnt_d;
  logic              phase_q, phase_d, present_c, d_s;

  assign d_s       = sync_q[1];
  // A line held low for all 16 bits reads as every button pressed: no pad.
  assign present_c = ~&raw_q;

  always_comb begin
    dec      = present_c ? {raw_q[1], raw_q[9], raw_q[7:2], raw_q[0], raw_q[8]} : '0;
    prev_d   = prev_q;
    match_d  = match_q;
    stable_d = stable_q;
    tcnt_d   = tcnt_q + 1'b1;
    phase_d  = phase_q;
    if (dec == prev_q) begin
      if (match_q != DB) match_d = match_q + 4'd1;
    end else begin
      match_d = 4'd1;
      prev_d  = dec;
    end
    if (match_d == DB) stable_d = dec;
    if (tcnt_q == TD_LAST) begin
      tcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      wait_q    <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      raw_q     <= '0;
      latch_q   <= 1'b0;
      jclk_q    <= 1'b1;
      done_q    <= 1'b0;
      present_q <= 1'b0;
      prev_q    <= '0;
      stable_q  <= '0;
      match_q   <= '0;
      tcnt_q    <= '0;
      phase_q   <= 1'b1;
      vec_q     <= '0;
    end else begin
      sync_q <= {sync_q[0], i_jp_data};
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (wait_q == WAIT_LAST) begin
            wait_q  <= '0;
            latch_q <= 1'b1;
            state_q <= S_LATCH;
          end else wait_q <= wait_q + 1'b1;
        S_LATCH:
          if (cnt_q == LATCH_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            latch_q <= 1'b0;
            jclk_q  <= 1'b0;
            state_q <= S_SHIFT;
          end else cnt_q <= cnt_q + 1'b1;
        S_SHIFT:
          if (cnt_q != PH_LAST) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q <= '0;
            if (!jclk_q) begin
              // After 16 shifts bit k of the scan sits at raw_q[k].
              raw_q  <= {~d_s, raw_q[15:1]};
              jclk_q <= 1'b1;
            end else if (bit_q == 4'd15) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              bit_q  <= bit_q + 4'd1;
              jclk_q <= 1'b0;
            end
          end
        S_DONE: begin
          state_q   <= S_IDLE;
          present_q <= present_c;
          prev_q    <= prev_d;
          match_q   <= match_d;
          stable_q  <= stable_d;
          tcnt_q    <= tcnt_d;
          phase_q   <= phase_d;
          vec_q     <= {stable_d[9] & phase_d, stable_d[8] & phase_d, stable_d[7:0]};
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_jp_latch    = latch_q;
  assign o_jp_clk      = jclk_q;
  assign o_jp_vec      = vec_q;
  assign o_pad_present = present_q;
  assign o_scan_done   = done_q;
endmodule
